// File: rtl/vending_core_param.sv
// Vending-machine core: per-item price/stock table, coin credit with ceiling, vend with stock
// decrement, change/refund over a valid/ack handshake, and inactivity auto-refund.
module vending_core_param #(
  parameter int N_ITEMS    = 8,
  parameter int SEL_W      = 3,
  parameter int CREDIT_W   = 7,
  parameter int STOCK_W    = 4,
  parameter int MAX_CREDIT = 100,
  parameter int COIN1_VAL  = 5,
  parameter int COIN2_VAL  = 10,
  parameter int COIN3_VAL  = 20,
  parameter int TIMEOUT    = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic                vend_req,
  input  logic [SEL_W-1:0]    select,
  input  logic                cancel,
  input  logic                change_ack,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_addr,
  input  logic [CREDIT_W-1:0] cfg_price,
  input  logic [STOCK_W-1:0]  cfg_stock,
  output logic [CREDIT_W-1:0] credit,
  output logic [SEL_W-1:0]    product_out,
  output logic                vend_valid,
  output logic [CREDIT_W-1:0] change,
  output logic                change_valid,
  output logic                coin_reject,
  output logic                err_funds,
  output logic                err_soldout,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  localparam bit TO_EN = (TIMEOUT != 0);
  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W + 1)'(MAX_CREDIT);

  state_t              state;
  logic [CREDIT_W-1:0] price_tab [N_ITEMS];
  logic [STOCK_W-1:0]  stock_tab [N_ITEMS];
  logic [TIMER_W-1:0]  timer;

  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_over;
  logic                coin_any;
  logic                sel_ok;
  logic [CREDIT_W-1:0] sel_price;
  logic [STOCK_W-1:0]  sel_stock;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    coin_val = '0;
    unique case (coin)
      2'b01:   coin_val = CREDIT_W'(COIN1_VAL);
      2'b10:   coin_val = CREDIT_W'(COIN2_VAL);
      2'b11:   coin_val = CREDIT_W'(COIN3_VAL);
      default: coin_val = '0;
    endcase
    coin_any  = (coin != 2'b00);
    coin_sum  = {1'b0, credit} + {1'b0, coin_val};
    coin_over = (coin_sum > MAX_C);
  end

  // Decoded table lookup; an index outside the table reads as sold out.
  always_comb begin
    sel_ok    = 1'b0;
    sel_price = '0;
    sel_stock = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (select == SEL_W'(i)) begin
        sel_ok    = 1'b1;
        sel_price = price_tab[i];
        sel_stock = stock_tab[i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      credit       <= '0;
      product_out  <= '0;
      vend_valid   <= 1'b0;
      change       <= '0;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      err_funds    <= 1'b0;
      err_soldout  <= 1'b0;
      busy         <= 1'b0;
      timer        <= '0;
      // NOTE: the tables are reset on purpose: after reset every item must read as sold out.
      for (int i = 0; i < N_ITEMS; i++) begin
        price_tab[i] <= '0;
        stock_tab[i] <= '0;
      end
    end else begin
      vend_valid  <= 1'b0;
      coin_reject <= 1'b0;
      err_funds   <= 1'b0;
      err_soldout <= 1'b0;

      unique case (state)
        IDLE: begin
          if (cfg_we) begin
            for (int i = 0; i < N_ITEMS; i++) begin
              if (cfg_addr == SEL_W'(i)) begin
                price_tab[i] <= cfg_price;
                stock_tab[i] <= cfg_stock;
              end
            end
          end
          if (coin_any) begin
            if (coin_over) begin
              coin_reject <= 1'b1;
            end else begin
              credit <= coin_sum[CREDIT_W-1:0];
              timer  <= '0;
              state  <= CREDIT;
            end
          end
        end

        CREDIT: begin
          if (cancel) begin
            coin_reject  <= coin_any;
            change       <= credit;
            change_valid <= 1'b1;
            busy         <= 1'b1;
            timer        <= '0;
            state        <= CHANGE;
          end else if (vend_req) begin
            coin_reject <= coin_any;
            timer       <= '0;
            if (!sel_ok || sel_stock == '0) begin
              err_soldout <= 1'b1;
            end else if (credit < sel_price) begin
              err_funds <= 1'b1;
            end else begin
              vend_valid  <= 1'b1;
              product_out <= select;
              credit      <= credit - sel_price;
              busy        <= 1'b1;
              state       <= VEND;
              for (int i = 0; i < N_ITEMS; i++) begin
                if (select == SEL_W'(i)) stock_tab[i] <= stock_tab[i] - STOCK_W'(1);
              end
            end
          end else if (coin_any) begin
            timer <= '0;
            if (coin_over) coin_reject <= 1'b1;
            else           credit      <= coin_sum[CREDIT_W-1:0];
          end else if (TO_EN && timer == TIMEOUT_LAST) begin
            // Inactivity auto-refund of the whole credit.
            change       <= credit;
            change_valid <= 1'b1;
            busy         <= 1'b1;
            timer        <= '0;
            state        <= CHANGE;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        VEND: begin
          coin_reject <= coin_any;
          if (credit != '0) begin
            change       <= credit;
            change_valid <= 1'b1;
            state        <= CHANGE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        CHANGE: begin
          coin_reject <= coin_any;
          if (change_ack) begin
            change       <= '0;
            change_valid <= 1'b0;
            credit       <= '0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_core_param.sv
// Directed bench for vending_core_param: inputs change 1 time unit after a rising edge and
// outputs are checked there, so each check sees the result of the edge just taken.
module tb_vending_core_param;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] coin;
  logic       vend_req;
  logic [2:0] select;
  logic       cancel;
  logic       change_ack;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [6:0] cfg_price;
  logic [3:0] cfg_stock;
  logic [6:0] credit;
  logic [2:0] product_out;
  logic       vend_valid;
  logic [6:0] change;
  logic       change_valid;
  logic       coin_reject;
  logic       err_funds;
  logic       err_soldout;
  logic       busy;

  int passed = 0;
  int total  = 0;

  vending_core_param dut (
    .clk(clk), .reset(reset), .coin(coin), .vend_req(vend_req), .select(select),
    .cancel(cancel), .change_ack(change_ack), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_price(cfg_price), .cfg_stock(cfg_stock), .credit(credit), .product_out(product_out),
    .vend_valid(vend_valid), .change(change), .change_valid(change_valid),
    .coin_reject(coin_reject), .err_funds(err_funds), .err_soldout(err_soldout), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] code);
    coin = code;
    tick();
    coin = 2'b00;
  endtask

  task automatic vend(input logic [2:0] sel);
    vend_req = 1'b1;
    select   = sel;
    tick();
    vend_req = 1'b0;
  endtask

  task automatic cfg(input logic [2:0] addr, input logic [6:0] price, input logic [3:0] stock);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_price = price;
    cfg_stock = stock;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic ack();
    change_ack = 1'b1;
    tick();
    change_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; coin = 2'b00; vend_req = 1'b0; select = '0; cancel = 1'b0;
    change_ack = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_price = '0; cfg_stock = '0;
    tick();
    tick();
    check("rst_credit", 32'(credit), 0);
    check("rst_outputs", 32'({vend_valid, change_valid, coin_reject, err_funds, err_soldout, busy}), 0);
    check("rst_change", 32'(change), 0);
    reset = 1'b0;
    tick();

    // 1: exact-price vend, no change
    cfg(3'd2, 7'd15, 4'd1);
    put_coin(2'b01);
    check("t1_credit5", 32'(credit), 5);
    put_coin(2'b10);
    check("t1_credit15", 32'(credit), 15);
    vend(3'd2);
    check("t1_vend_valid", 32'(vend_valid), 1);
    check("t1_product", 32'(product_out), 2);
    check("t1_credit0", 32'(credit), 0);
    check("t1_busy", 32'(busy), 1);
    tick();
    check("t1_vend_pulse", 32'(vend_valid), 0);
    check("t1_no_change", 32'(change_valid), 0);
    check("t1_idle", 32'(busy), 0);

    // 2: sold out, then cancel refund held until ack
    put_coin(2'b11);
    check("t2_credit20", 32'(credit), 20);
    vend(3'd2);
    check("t2_soldout", 32'(err_soldout), 1);
    check("t2_no_vend", 32'(vend_valid), 0);
    tick();
    check("t2_soldout_pulse", 32'(err_soldout), 0);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("t2_cv", 32'(change_valid), 1);
    check("t2_change20", 32'(change), 20);
    check("t2_credit_shown", 32'(credit), 20);
    tick();
    tick();
    check("t2_cv_held", 32'(change_valid), 1);
    put_coin(2'b01);
    check("t2_coin_in_change", 32'(coin_reject), 1);
    check("t2_change_held", 32'(change), 20);
    ack();
    check("t2_cv_clear", 32'(change_valid), 0);
    check("t2_change_clear", 32'(change), 0);
    check("t2_credit_clear", 32'(credit), 0);
    check("t2_busy_clear", 32'(busy), 0);

    // 3: insufficient funds, top up, vend
    cfg(3'd3, 7'd25, 4'd2);
    cfg(3'd5, 7'd10, 4'd3);
    put_coin(2'b10);
    put_coin(2'b10);
    check("t3_credit20", 32'(credit), 20);
    vend(3'd3);
    check("t3_err_funds", 32'(err_funds), 1);
    check("t3_credit_kept", 32'(credit), 20);
    put_coin(2'b01);
    check("t3_credit25", 32'(credit), 25);
    vend(3'd3);
    check("t3_vend", 32'(vend_valid), 1);
    check("t3_product", 32'(product_out), 3);
    check("t3_credit0", 32'(credit), 0);
    tick();

    // 4: credit ceiling, then vend leaving change
    for (int i = 1; i <= 5; i++) begin
      put_coin(2'b11);
      check("t4_coin_ok", 32'(coin_reject), 0);
    end
    check("t4_credit100", 32'(credit), 100);
    put_coin(2'b11);
    check("t4_reject", 32'(coin_reject), 1);
    check("t4_credit_cap", 32'(credit), 100);
    vend(3'd3);
    check("t4_vend", 32'(vend_valid), 1);
    check("t4_credit75", 32'(credit), 75);
    tick();
    check("t4_cv", 32'(change_valid), 1);
    check("t4_change75", 32'(change), 75);
    check("t4_busy", 32'(busy), 1);
    ack();
    check("t4_idle", 32'(change_valid), 0);

    // 5: inactivity auto-refund after 20 quiet cycles
    put_coin(2'b11);
    put_coin(2'b10);
    check("t5_credit30", 32'(credit), 30);
    for (int i = 0; i < 19; i++) tick();
    check("t5_not_yet", 32'(change_valid), 0);
    tick();
    check("t5_timeout_cv", 32'(change_valid), 1);
    check("t5_timeout_change", 32'(change), 30);
    ack();
    put_coin(2'b11);
    cancel = 1'b1; vend_req = 1'b1; select = 3'd5; coin = 2'b01;
    tick();
    cancel = 1'b0; vend_req = 1'b0; coin = 2'b00;
    check("t5_prio_cv", 32'(change_valid), 1);
    check("t5_prio_change", 32'(change), 20);
    check("t5_prio_reject", 32'(coin_reject), 1);
    check("t5_prio_no_vend", 32'(vend_valid), 0);

    // 6: asynchronous reset during CHANGE, then cleared tables and cfg ignored in CREDIT
    reset = 1'b1;
    #1;
    check("t6_async_cv", 32'(change_valid), 0);
    check("t6_async_change", 32'(change), 0);
    check("t6_async_credit", 32'(credit), 0);
    check("t6_async_busy", 32'(busy), 0);
    reset = 1'b0;
    tick();
    put_coin(2'b11);
    vend(3'd5);
    check("t6_table_cleared", 32'(err_soldout), 1);
    cfg(3'd6, 7'd5, 4'd5);
    check("t6_cfg_credit", 32'(credit), 20);
    vend(3'd6);
    check("t6_cfg_ignored", 32'(err_soldout), 1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    ack();
    cfg(3'd6, 7'd5, 4'd5);
    put_coin(2'b01);
    vend(3'd6);
    check("t6_cfg_idle_vend", 32'(vend_valid), 1);
    check("t6_cfg_idle_product", 32'(product_out), 6);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
